// File: rtl/riscv_if_prefetch.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue.
// It issues one ICACHE read per cycle and hands instructions to ID over valid/ready.
module riscv_if_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 pc_src,
    input  logic [XLEN-1:0]            pc_j,
    input  logic [XLEN-1:0]            pc_branch,
    input  logic                       ICACHE_stall,
    output logic                       ICACHE_ren,
    output logic                       ICACHE_wen,
    output logic [XLEN-1:0]            ICACHE_addr,
    input  logic [31:0]                ICACHE_rdata,
    output logic [31:0]                ICACHE_wdata,
    input  logic                       id_ready,
    output logic                       inst_valid,
    output logic [31:0]                inst_ppl,
    output logic [XLEN-1:0]            pc_ppl,
    output logic [$clog2(DEPTH):0]     fetch_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] pc_r;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic [XLEN-1:0] q_pc   [DEPTH];
    logic [31:0]     q_inst [DEPTH];

    logic            pop;
    logic            full;
    logic            redirect;
    logic            accept;
    logic [XLEN-1:0] target_raw;
    logic [XLEN-1:0] target;

    always_comb begin
        redirect   = 1'b0;
        target_raw = pc_j;
        case (pc_src)
            2'b01: begin
                redirect   = 1'b1;
                target_raw = pc_j;
            end
            2'b10: begin
                redirect   = 1'b1;
                target_raw = pc_branch;
            end
            default: begin
                redirect   = 1'b0;
                target_raw = pc_j;
            end
        endcase
    end

    // Targets are word aligned; the low two bits are dropped rather than trapped.
    assign target = {target_raw[XLEN-1:2], 2'b00};

    assign inst_valid = (count != '0);
    assign pop        = inst_valid && id_ready;
    assign full       = (count == CW'(DEPTH));
    // A full queue still fetches when the head leaves this cycle, so the stream has no bubble.
    assign ICACHE_ren = !full || pop;
    assign accept     = ICACHE_ren && !ICACHE_stall && !redirect;

    assign ICACHE_addr  = pc_r;
    assign ICACHE_wen   = 1'b0;
    assign ICACHE_wdata = 32'h0;
    assign fetch_count  = count;

    assign inst_ppl = inst_valid ? q_inst[rd_ptr] : NOP;
    assign pc_ppl   = inst_valid ? q_pc[rd_ptr]   : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r   <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            pc_r   <= target;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                pc_r   <= pc_r + XLEN'(4);
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !accept) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_pc[wr_ptr]   <= pc_r;
            q_inst[wr_ptr] <= ICACHE_rdata;
        end
    end

endmodule

// File: tb/tb_riscv_if_prefetch.sv
// Directed bench for riscv_if_prefetch: reset, streaming, backpressure, stall,
// redirects (including while full and while stalled) and PC wrap.
module tb_riscv_if_prefetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  pc_src;
    logic [31:0] pc_j;
    logic [31:0] pc_branch;
    logic        ICACHE_stall;
    logic        ICACHE_ren;
    logic        ICACHE_wen;
    logic [31:0] ICACHE_addr;
    logic [31:0] ICACHE_rdata;
    logic [31:0] ICACHE_wdata;
    logic        id_ready;
    logic        inst_valid;
    logic [31:0] inst_ppl;
    logic [31:0] pc_ppl;
    logic [2:0]  fetch_count;

    int n_chk  = 0;
    int n_pass = 0;

    riscv_if_prefetch #(
        .XLEN(32), .DEPTH(4), .RESET_PC(32'h100), .NOP(32'h0000_0013)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .pc_j(pc_j), .pc_branch(pc_branch),
        .ICACHE_stall(ICACHE_stall), .ICACHE_ren(ICACHE_ren), .ICACHE_wen(ICACHE_wen),
        .ICACHE_addr(ICACHE_addr), .ICACHE_rdata(ICACHE_rdata), .ICACHE_wdata(ICACHE_wdata),
        .id_ready(id_ready), .inst_valid(inst_valid), .inst_ppl(inst_ppl), .pc_ppl(pc_ppl),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0000;
    endfunction

    // Cache model: address-tagged data, garbage while stalled.
    assign ICACHE_rdata = ICACHE_stall ? 32'hDEAD_BEEF : tag(ICACHE_addr);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; pc_src = 2'b00; pc_j = '0; pc_branch = '0;
        ICACHE_stall = 1'b0; id_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("rst_addr",  ICACHE_addr, 32'h100);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst",  inst_ppl, 32'h0000_0013);
        check("rst_pc",    pc_ppl, 32'h0);
        check("rst_count", 32'(fetch_count), 32'd0);
        check("rst_ren",   32'(ICACHE_ren), 32'd1);
        check("rst_wen",   32'(ICACHE_wen), 32'd0);
        check("rst_wdata", ICACHE_wdata, 32'h0);

        tick();
        check("first_pc",    pc_ppl, 32'h100);
        check("first_inst",  inst_ppl, tag(32'h100));
        check("first_count", 32'(fetch_count), 32'd1);
        check("first_addr",  ICACHE_addr, 32'h104);

        // Redirect to 0, then stream with id_ready=1.
        pc_src = 2'b01; pc_j = 32'h0;
        tick();
        check("rd0_count", 32'(fetch_count), 32'd0);
        check("rd0_addr",  ICACHE_addr, 32'h0);
        pc_src = 2'b00; id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stream_pc",    pc_ppl, 32'(4 * i));
            check("stream_inst",  inst_ppl, tag(32'(4 * i)));
            check("stream_count", 32'(fetch_count), 32'd1);
        end

        // Backpressure: restart at 0 with id_ready low for 8 cycles.
        pc_src = 2'b01; pc_j = 32'h0; id_ready = 1'b0;
        tick();
        pc_src = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("bp_count", 32'(fetch_count), (k < 4) ? 32'(k) : 32'd4);
        end
        check("bp_ren",  32'(ICACHE_ren), 32'd0);
        check("bp_addr", ICACHE_addr, 32'h10);
        check("bp_head", pc_ppl, 32'h0);
        check("bp_inst", inst_ppl, tag(32'h0));
        id_ready = 1'b1;
        #1;
        check("bp_ren_pop", 32'(ICACHE_ren), 32'd1);
        for (int j = 1; j <= 6; j++) begin
            tick();
            check("drain_pc",    pc_ppl, 32'(4 * j));
            check("drain_count", 32'(fetch_count), 32'd4);
        end

        // Stall for 3 cycles at address 0x8.
        pc_src = 2'b01; pc_j = 32'h0;
        tick();
        pc_src = 2'b00;
        tick();
        tick();
        check("pre_stall_pc", pc_ppl, 32'h4);
        ICACHE_stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            check("stall_addr", ICACHE_addr, 32'h8);
            tick();
        end
        check("stall_addr_end", ICACHE_addr, 32'h8);
        check("stall_count", 32'(fetch_count), 32'd0);
        check("stall_valid", 32'(inst_valid), 32'd0);
        ICACHE_stall = 1'b0;
        tick();
        check("unstall_pc",    pc_ppl, 32'h8);
        check("unstall_inst",  inst_ppl, tag(32'h8));
        check("unstall_count", 32'(fetch_count), 32'd1);
        tick();
        check("unstall_next", pc_ppl, 32'hC);

        // Fill, then branch redirect while full.
        id_ready = 1'b0;
        for (int f = 0; f < 5; f++) tick();
        check("full_count", 32'(fetch_count), 32'd4);
        pc_src = 2'b10; pc_branch = 32'h203;
        tick();
        check("br_valid", 32'(inst_valid), 32'd0);
        check("br_count", 32'(fetch_count), 32'd0);
        check("br_addr",  ICACHE_addr, 32'h200);
        pc_src = 2'b00; id_ready = 1'b1;
        tick();
        check("br_pc",    pc_ppl, 32'h200);
        check("br_valid2", 32'(inst_valid), 32'd1);

        // Jump concurrent with a stall.
        ICACHE_stall = 1'b1; pc_src = 2'b01; pc_j = 32'h40;
        tick();
        check("js_addr",  ICACHE_addr, 32'h40);
        check("js_valid", 32'(inst_valid), 32'd0);
        check("js_count", 32'(fetch_count), 32'd0);
        ICACHE_stall = 1'b0; pc_src = 2'b00;
        tick();
        check("js_pc",   pc_ppl, 32'h40);
        check("js_inst", inst_ppl, tag(32'h40));
        tick();
        check("js_pc2",  pc_ppl, 32'h44);

        // Unaligned jump near the top of the address space, then wrap; pc_src=11 is ignored.
        pc_src = 2'b01; pc_j = 32'hFFFF_FFFF;
        tick();
        check("wrap_addr", ICACHE_addr, 32'hFFFF_FFFC);
        pc_src = 2'b00;
        tick();
        check("wrap_pc",    pc_ppl, 32'hFFFF_FFFC);
        check("wrap_addr2", ICACHE_addr, 32'h0);
        pc_src = 2'b11; pc_j = 32'h300; pc_branch = 32'h300;
        tick();
        check("src11_addr", ICACHE_addr, 32'h4);
        check("src11_pc",   pc_ppl, 32'h0);
        pc_src = 2'b00;

        // Asynchronous reset mid-operation clears the queue immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(inst_valid), 32'd0);
        check("arst_addr",  ICACHE_addr, 32'h100);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
